// File: rtl/serie_paralelo_alineado.sv
// serie_paralelo_alineado
//   Serial-to-parallel receiver with comma alignment, clocked by the bit
//   clock only. It hunts for COMMA at any bit offset, then needs LOCK_COUNT
//   consecutive aligned commas before it declares lock. Once locked, every
//   word boundary produces a one-cycle strobe. A data word is presented with
//   valid_out=1. An idle comma gives valid_out=0, and data_out holds.
// Ports
//   clk_8f       bit clock, all state updates on posedge
//   reset        asynchronous active-low clear
//   data_in      serial bit, MSB first
//   resync       synchronous request to drop lock and re-hunt
//   data_out     last received non-comma word
//   valid_out    data_out belongs to the current boundary
//   active       receiver is locked
//   word_strobe  one-cycle pulse on each boundary while locked
module serie_paralelo_alineado #(
  parameter int unsigned          WIDTH      = 8,
  parameter logic [WIDTH-1:0]     COMMA      = 8'hBC,
  parameter int unsigned          LOCK_COUNT = 4
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             data_in,
  input  logic             resync,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic             word_strobe
);

  localparam int unsigned CW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BW = $clog2(WIDTH);

  typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    comma_cnt;

  logic [WIDTH-1:0] nxt;
  logic             boundary;
  logic             is_comma;
  logic [BW-1:0]    bit_cnt_adv;
  logic             lock_done;

  always_comb begin
    nxt         = {sr[WIDTH-2:0], data_in};
    boundary    = (bit_cnt == BW'(WIDTH - 1));
    is_comma    = (nxt == COMMA);
    bit_cnt_adv = boundary ? '0 : bit_cnt + BW'(1);
    lock_done   = ((comma_cnt + CW'(1)) == CW'(LOCK_COUNT));
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      sr          <= '0;
      bit_cnt     <= '0;
      comma_cnt   <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      active      <= 1'b0;
      word_strobe <= 1'b0;
    end else begin
      // The shifter runs in every state, including the resync edge.
      sr          <= nxt;
      word_strobe <= 1'b0;
      if (resync) begin
        state     <= SEARCH;
        bit_cnt   <= '0;
        comma_cnt <= '0;
        valid_out <= 1'b0;
        active    <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            bit_cnt <= bit_cnt_adv;
            if (is_comma) begin
              // The comma just completed defines the word boundary.
              bit_cnt   <= '0;
              comma_cnt <= CW'(1);
              if (LOCK_COUNT == 1) begin
                state  <= LOCKED;
                active <= 1'b1;
              end else begin
                state <= SYNC;
              end
            end
          end
          SYNC: begin
            bit_cnt <= bit_cnt_adv;
            if (boundary) begin
              if (is_comma) begin
                comma_cnt <= comma_cnt + CW'(1);
                if (lock_done) begin
                  state  <= LOCKED;
                  active <= 1'b1;
                end
              end else begin
                state     <= SEARCH;
                comma_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            bit_cnt <= bit_cnt_adv;
            if (boundary) begin
              word_strobe <= 1'b1;
              if (is_comma) begin
                valid_out <= 1'b0;
              end else begin
                data_out  <= nxt;
                valid_out <= 1'b1;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serie_paralelo_alineado.sv
// tb_serie_paralelo_alineado
//   Directed bench for serie_paralelo_alineado (WIDTH=8, COMMA=BC,
//   LOCK_COUNT=4). Bits are driven on the falling edge and outputs are
//   sampled 1 ns after the rising edge.
module tb_serie_paralelo_alineado;

  logic       clk_8f = 1'b0;
  logic       reset  = 1'b0;
  logic       data_in = 1'b0;
  logic       resync  = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       word_strobe;

  int unsigned checks = 0;
  int unsigned errors = 0;

  serie_paralelo_alineado #(
    .WIDTH      (8),
    .COMMA      (8'hBC),
    .LOCK_COUNT (4)
  ) dut (
    .clk_8f      (clk_8f),
    .reset       (reset),
    .data_in     (data_in),
    .resync      (resync),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active      (active),
    .word_strobe (word_strobe)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic put_bit(input logic b, input logic rs);
    @(negedge clk_8f);
    data_in = b;
    resync  = rs;
    @(posedge clk_8f);
    #1;
  endtask

  // Sends one word MSB first; the strobe must be low one edge after any boundary.
  task automatic send_byte(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      put_bit(w[7-i], 1'b0);
      if (i == 0) chk("strobe_mid", 32'(word_strobe), 32'h0);
    end
  endtask

  // Four commas; lock must appear exactly at the fourth.
  task automatic lock_seq(input string tag);
    for (int n = 1; n <= 4; n++) begin
      send_byte(8'hBC);
      chk(tag, 32'(active), (n == 4) ? 32'h1 : 32'h0);
    end
    chk({tag, "_valid"}, 32'(valid_out), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    // 1: reset held with toggling data
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_8f);
      data_in = ~data_in;
    end
    #1;
    chk("rst_data",   32'(data_out),    32'h0);
    chk("rst_valid",  32'(valid_out),   32'h0);
    chk("rst_active", 32'(active),      32'h0);
    chk("rst_strobe", 32'(word_strobe), 32'h0);
    @(negedge clk_8f);
    data_in = 1'b0;
    reset   = 1'b1;
    send_byte(8'h00);
    chk("idle_active", 32'(active), 32'h0);
    send_byte(8'h00);
    chk("idle_active2", 32'(active), 32'h0);
    chk("idle_strobe",  32'(word_strobe), 32'h0);

    // 2: junk bits 101, BC x4, then data
    put_bit(1'b1, 1'b0);
    put_bit(1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    lock_seq("lock2");
    send_byte(8'hFF);
    chk("d_ff", 32'(data_out), 32'hFF); chk("v_ff", 32'(valid_out), 32'h1); chk("s_ff", 32'(word_strobe), 32'h1);
    send_byte(8'hEE);
    chk("d_ee", 32'(data_out), 32'hEE); chk("v_ee", 32'(valid_out), 32'h1); chk("s_ee", 32'(word_strobe), 32'h1);
    send_byte(8'h4E);
    chk("d_4e", 32'(data_out), 32'h4E); chk("v_4e", 32'(valid_out), 32'h1); chk("s_4e", 32'(word_strobe), 32'h1);
    send_byte(8'h44);
    chk("d_44", 32'(data_out), 32'h44); chk("v_44", 32'(valid_out), 32'h1); chk("s_44", 32'(word_strobe), 32'h1);

    // 3: idle comma while locked
    send_byte(8'hBC);
    chk("idle_d", 32'(data_out), 32'h44); chk("idle_v", 32'(valid_out), 32'h0); chk("idle_s", 32'(word_strobe), 32'h1);
    chk("idle_act", 32'(active), 32'h1);

    // 4: drop lock, then BC,BC,11 must fall back to SEARCH
    put_bit(1'b0, 1'b1);
    chk("rs4_active", 32'(active), 32'h0);
    for (int i = 0; i < 7; i++) put_bit(1'b0, 1'b0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h11);
    chk("fail_active", 32'(active), 32'h0);
    chk("fail_strobe", 32'(word_strobe), 32'h0);
    lock_seq("lock4");

    // 5: data word, then resync at bit 3 of the following word
    send_byte(8'h12);
    chk("d_12", 32'(data_out), 32'h12); chk("v_12", 32'(valid_out), 32'h1);
    w = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      put_bit(w[7-i], (i == 3) ? 1'b1 : 1'b0);
      if (i == 3) begin
        chk("rs5_active", 32'(active), 32'h0);
        chk("rs5_valid",  32'(valid_out), 32'h0);
      end
    end
    chk("rs5_nostrobe", 32'(word_strobe), 32'h0);
    chk("rs5_hold",     32'(data_out), 32'h12);
    lock_seq("lock5");
    send_byte(8'h77);
    chk("d_77", 32'(data_out), 32'h77); chk("v_77", 32'(valid_out), 32'h1); chk("s_77", 32'(word_strobe), 32'h1);

    // 6: async reset at bit 5 of a word
    w = 8'hA5;
    for (int i = 0; i < 5; i++) put_bit(w[7-i], 1'b0);
    chk("pre6_active", 32'(active), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_data",   32'(data_out),    32'h0);
    chk("ar_valid",  32'(valid_out),   32'h0);
    chk("ar_active", 32'(active),      32'h0);
    chk("ar_strobe", 32'(word_strobe), 32'h0);
    @(negedge clk_8f);
    @(negedge clk_8f);
    reset = 1'b1;
    lock_seq("lock6");
    send_byte(8'h3C);
    chk("d_3c", 32'(data_out), 32'h3C); chk("v_3c", 32'(valid_out), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
